// File: rtl/parity_pkg.sv
// parity_pkg: shared types and constants for the serial parity checker.
`default_nettype none

package parity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/serial_parity_acc.sv
// serial_parity_acc: deserialising shift register with running XOR and bit index.
`default_nettype none

module serial_parity_acc #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data,
  output logic              acc,
  output logic              last
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sr_next;

  generate
    if (DATA_W == 1) begin : g_single
      assign sr_next = bit_in;
    end else if (MSB_FIRST) begin : g_msb_first
      assign sr_next = {sr[DATA_W-2:0], bit_in};
    end else begin : g_lsb_first
      assign sr_next = {bit_in, sr[DATA_W-1:1]};
    end
  endgenerate

  // High while the bit about to be accepted is the last data bit of the frame.
  assign last = (idx == IDX_W'(DATA_W - 1));
  assign data = sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      idx <= '0;
      acc <= 1'b0;
    end else if (clear) begin
      idx <= '0;
      acc <= 1'b0;
    end else if (shift) begin
      sr  <= sr_next;
      acc <= acc ^ bit_in;
      idx <= last ? '0 : idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_parity_checker.sv
// serial_parity_checker: streaming even/odd parity check of DATA_W-bit serial frames
// with per-frame, sticky and saturating-count error reporting.
`default_nettype none

module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              odd_mode,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              clr_cnt,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              parity_err,
  output logic              sticky_err,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy
);

  state_t            state;
  logic              odd_latched;
  logic [DATA_W-1:0] acc_data;
  logic              acc_xor;
  logic              acc_last;
  logic              shift;
  logic              done;
  logic              err;

  // A start cycle carries no data bit, so it clears rather than shifts.
  assign shift = (state == ST_DATA) && bit_valid && !start;
  assign done  = (state == ST_PARITY) && bit_valid;
  assign err   = acc_xor ^ bit_in ^ (odd_latched == PAR_ODD);

  serial_parity_acc #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .shift  (shift),
    .bit_in (bit_in),
    .data   (acc_data),
    .acc    (acc_xor),
    .last   (acc_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      odd_latched <= PAR_EVEN;
      data_out    <= '0;
      out_valid   <= 1'b0;
      parity_err  <= 1'b0;
      sticky_err  <= 1'b0;
      err_count   <= '0;
      busy        <= 1'b0;
    end else begin
      out_valid <= 1'b0;

      if (clr_cnt) begin
        err_count  <= '0;
        sticky_err <= 1'b0;
      end

      // Completion wins over a coincident start; the new frame still begins below.
      if (done) begin
        data_out   <= acc_data;
        parity_err <= err;
        out_valid  <= 1'b1;
        if (err) begin
          sticky_err <= 1'b1;
          if (clr_cnt)
            err_count <= CNT_W'(1);
          else if (err_count != {CNT_W{1'b1}})
            err_count <= err_count + 1'b1;
        end
      end

      if (start) begin
        state       <= ST_DATA;
        odd_latched <= odd_mode;
        busy        <= 1'b1;
      end else begin
        case (state)
          ST_DATA: begin
            if (bit_valid && acc_last)
              state <= ST_PARITY;
          end
          ST_PARITY: begin
            if (bit_valid) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_parity_checker.sv
// tb_serial_parity_checker: randomized self-checking bench against a frame-level model.
`default_nettype none

module tb_serial_parity_checker;

  logic       clk = 1'b0;
  logic       rst, start, odd_mode, bit_in, bit_valid, clr_cnt;
  logic [7:0] data_out;
  logic       out_valid, parity_err, sticky_err, busy;
  logic [1:0] err_count;

  logic       start5, odd_mode5, bit_in5, bit_valid5;
  logic [4:0] data_out5;
  logic       out_valid5, parity_err5, sticky_err5, busy5;
  logic [3:0] err_count5;

  int checks = 0;
  int failures = 0;
  int spurious = 0;
  bit expect_ov = 1'b0;
  int m_cnt = 0;
  bit m_sticky = 1'b0;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(8), .CNT_W(2), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .odd_mode(odd_mode), .bit_in(bit_in),
    .bit_valid(bit_valid), .clr_cnt(clr_cnt), .data_out(data_out), .out_valid(out_valid),
    .parity_err(parity_err), .sticky_err(sticky_err), .err_count(err_count), .busy(busy)
  );

  serial_parity_checker #(.DATA_W(5), .CNT_W(4), .MSB_FIRST(1'b0)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .odd_mode(odd_mode5), .bit_in(bit_in5),
    .bit_valid(bit_valid5), .clr_cnt(1'b0), .data_out(data_out5), .out_valid(out_valid5),
    .parity_err(parity_err5), .sticky_err(sticky_err5), .err_count(err_count5), .busy(busy5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (out_valid && !expect_ov) spurious++;
  endtask

  task automatic gap(input bit en);
    if (en) begin
      repeat ($urandom_range(0, 3)) begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom);
        tick();
      end
    end
  endtask

  // One 8-bit frame on u_dut. chain asserts start together with the parity bit.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic odd,
                            input bit gaps, input bit clr, input bit skip_start,
                            input bit chain, input logic chain_odd);
    bit exp_err;
    if (!skip_start) begin
      start     = 1'b1;
      odd_mode  = odd;
      bit_valid = 1'($urandom);
      bit_in    = 1'($urandom);
      tick();
      start     = 1'b0;
      odd_mode  = 1'($urandom);
    end
    for (int i = 7; i >= 0; i--) begin
      gap(gaps);
      bit_valid = 1'b1;
      bit_in    = d[i];
      tick();
      bit_valid = 1'b0;
    end
    gap(gaps);
    bit_valid = 1'b1;
    bit_in    = p;
    clr_cnt   = clr;
    start     = chain;
    odd_mode  = chain_odd;
    expect_ov = 1'b1;
    tick();
    exp_err = (^d) ^ p ^ odd;
    if (clr) begin
      m_cnt    = 0;
      m_sticky = 1'b0;
    end
    if (exp_err) begin
      m_sticky = 1'b1;
      if (m_cnt < 3) m_cnt++;
    end
    check("out_valid", 32'(out_valid), 32'd1);
    check("data_out", 32'(data_out), 32'(d));
    check("parity_err", 32'(parity_err), 32'(exp_err));
    check("err_count", 32'(err_count), 32'(m_cnt));
    check("sticky_err", 32'(sticky_err), 32'(m_sticky));
    check("busy_after", 32'(busy), 32'(chain));
    bit_valid = 1'b0;
    clr_cnt   = 1'b0;
    start     = 1'b0;
    expect_ov = 1'b0;
  endtask

  // One 5-bit LSB-first frame on u_dut5: the i-th received bit lands in bit i.
  task automatic send5(input logic [4:0] d, input logic p, input logic odd);
    start5 = 1'b1;
    odd_mode5 = odd;
    tick();
    start5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valid5 = 1'b1;
      bit_in5    = d[i];
      tick();
      bit_valid5 = 1'b0;
      tick();
    end
    bit_valid5 = 1'b1;
    bit_in5    = p;
    tick();
    bit_valid5 = 1'b0;
    check("out_valid5", 32'(out_valid5), 32'd1);
    check("data_out5", 32'(data_out5), 32'(d));
    check("parity_err5", 32'(parity_err5), 32'((^d) ^ p ^ odd));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; odd_mode = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; clr_cnt = 1'b0;
    start5 = 1'b0; odd_mode5 = 1'b0; bit_in5 = 1'b0; bit_valid5 = 1'b0;
    tick(); tick();
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_sticky", 32'(sticky_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Stray bits in IDLE are ignored.
    bit_valid = 1'b1; bit_in = 1'b1; tick(); tick(); bit_valid = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);

    start = 1'b1; tick(); start = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Saturation at 3, then clear coinciding with a bad completion.
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    m_cnt = 0; m_sticky = 1'b0;
    check("clr_count", 32'(err_count), 32'd0);
    check("clr_sticky", 32'(sticky_err), 32'd0);
    repeat (5) send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("saturated", 32'(err_count), 32'd3);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Abort after 3 data bits, then a full frame.
    start = 1'b1; odd_mode = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1; bit_in = 1'($urandom); tick();
    end
    bit_valid = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; odd_mode = 1'b0; tick(); start = 1'b0;
    bit_valid = 1'b1; bit_in = 1'b1; tick(); bit_valid = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: start coincides with the parity bit.
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset while waiting for the parity bit.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1; tick();
    end
    bit_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    m_cnt = 0; m_sticky = 1'b0;
    check("midrst_data", 32'(data_out), 32'd0);
    check("midrst_err", 32'(parity_err), 32'd0);
    check("midrst_count", 32'(err_count), 32'd0);
    check("midrst_sticky", 32'(sticky_err), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'b1,
                 ($urandom_range(0, 3) == 0), 1'b0, 1'b0, 1'b0);
    end

    send5(5'b00001, 1'b1, 1'b0);
    for (int n = 0; n < 6; n++) send5(5'($urandom), 1'($urandom), 1'($urandom));

    check("no_spurious_out_valid", 32'(spurious), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
